reg_bank_a: RTL
===============

# reg_bank_a

Two-read, one-write operand register bank for the Kalman datapath. It sits directly downstream of the operand router and consumes the router's outputs: the 24-bit `data` bus, the `write` strobe, and the two read addresses `dira` and `dirb`. It stores 32 words of 24 bits and returns registered operand pairs to the arithmetic unit with a one-cycle read latency. It also has write-to-read bypass, a stall hold, and per-entry initialisation tracking.

## Interface
- `WIDTH`, 24, data word width.
- `AW`, 5, address width.
- `DEPTH`, 32, number of entries (2^AW).
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `data`  in  WIDTH  write data from the router.
- `waddr`  in  AW  write address (the router's `DIR`).
- `write`  in  1  write strobe from the router.
- `dira`  in  AW  read address, port A.
- `dirb`  in  AW  read address, port B.
- `rd_req`  in  1  read request; captures `dira`/`dirb`.
- `hold`  in  1  stall from downstream; freezes all outputs.
- `opa`  out  WIDTH  port A operand.
- `opb`  out  WIDTH  port B operand.
- `op_valid`  out  1  `opa`/`opb` hold a fresh result.
- `opa_init`  out  1  the port-A entry has been written since reset.
- `opb_init`  out  1  the port-B entry has been written since reset.
- `wr_ack`  out  1  a write was committed in the previous cycle.

## Operation
- Storage: `DEPTH` × `WIDTH` flop array `mem`, plus a `DEPTH`-bit vector `init_v`.
- Reset (synchronous, `rst`=1 at the edge):
  - `mem` all entries and `init_v` clear to 0.
  - `opa`, `opb` go to 0.
  - `op_valid`, `opa_init`, `opb_init`, `wr_ack` go to 0.
  - Any read or write presented in the same cycle is discarded.
- Write:
  - `write`=1 and `rst`=0: `mem[waddr]` ← `data` and `init_v[waddr]` ← 1 at the edge.
  - `wr_ack` is 1 in the following cycle, otherwise 0.
  - Writes are not blocked by `hold`.
- Read, when `rd_req`=1 and `hold`=0:
  - At the edge, `opa` ← the port-A value and `opb` ← the port-B value.
  - `opa_init`/`opb_init` ← the corresponding `init_v` bit.
  - `op_valid` ← 1.
- Bypass (write-first): if `write`=1 and `waddr`==`dira` in the read cycle, `opa` ← `data` and `opa_init` ← 1. Port B follows the same rule independently.
- Same address on both ports: `dira`==`dirb` is legal; both ports return the same value.
- `rd_req`=0 and `hold`=0: `op_valid` ← 0; `opa`/`opb`/init flags keep their last values.
- `hold`=1:
  - `opa`, `opb`, `op_valid`, `opa_init`, `opb_init` keep their values.
  - `rd_req` is ignored (not queued). Upstream must keep the request asserted until `hold` falls.
- Hold versus write: a write to an address whose value is already latched on `opa`/`opb` does not alter the latched output.
- Width rule: data is stored and returned unmodified. No sign extension, truncation or arithmetic.
- There is no state machine beyond the output register stage. Control is a single valid/hold pipeline register.

## Timing
- Read latency: 1 cycle, from the `rd_req` edge to valid `opa`/`opb`/`op_valid`.
- Write-to-read:
  - Same cycle: bypassed, returns the new data.
  - Next cycle: read from the array, returns the new data.
- Throughput: one read pair and one write per cycle, sustained.
- `wr_ack`: a 1-cycle pulse one cycle after each accepted write. Back-to-back writes give a continuous 1.
- Reset mid-operation: an in-flight read is dropped, `op_valid` is 0 in the cycle after `rst`, and no ack is produced for a write in the reset cycle.
- `hold` release: the first edge with `hold`=0 and `rd_req`=1 captures the current addresses. No stale or replayed request.

## Test plan
- Reset, then read A=3 and B=17: `opa`=`opb`=0, both init flags 0, `op_valid`=1 one cycle later.
- Write 0xABCDEF to entry 5, then the next cycle read A=5 and B=5: both ports return 0xABCDEF with init flags 1, and `wr_ack`=1 in the cycle after the write.
- In the same cycle, write 0x123456 to entry 9 and read A=9, B=8 (entry 8 previously holds 0x00000F): `opa`=0x123456 via bypass, `opb`=0x00000F.
- Latch `opa`=0x111111 from entry 2, raise `hold` for 3 cycles while writing 0x222222 to entry 2 and driving `rd_req`: outputs stay 0x111111 and `op_valid` is unchanged. After release, a read of entry 2 returns 0x222222.
- Write all 32 entries with value = address × 0x010101, then read pairs (i, 31−i) back-to-back with `rd_req` held high: every result matches, `op_valid` stays 1, `wr_ack` is continuous during the writes.
- Assert `rst` during back-to-back reads and a write to entry 7 (0xFFFFFF): the next cycle has `op_valid`=0, and a subsequent read of entry 7 returns 0 with `opa_init`=0.

Source files
------------

// File: rtl/reg_bank_a.sv
// Two-read, one-write operand register bank with write-first bypass, stall hold and
// per-entry initialisation tracking. One-cycle registered read latency.
module reg_bank_a #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned AW    = 5,
    parameter int unsigned DEPTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data,
    input  logic [AW-1:0]    waddr,
    input  logic             write,
    input  logic [AW-1:0]    dira,
    input  logic [AW-1:0]    dirb,
    input  logic             rd_req,
    input  logic             hold,
    output logic [WIDTH-1:0] opa,
    output logic [WIDTH-1:0] opb,
    output logic             op_valid,
    output logic             opa_init,
    output logic             opb_init,
    output logic             wr_ack
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] init_v_q;

    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             op_valid_q, op_valid_d;
    logic             opa_init_q, opa_init_d;
    logic             opb_init_q, opb_init_d;
    logic             wr_ack_q;

    logic             byp_a, byp_b;
    logic [WIDTH-1:0] rd_a, rd_b;
    logic             rd_a_init, rd_b_init;

    // Write-first: a same-cycle write to the read address wins over the array contents.
    always_comb begin
        byp_a     = write && (waddr == dira);
        byp_b     = write && (waddr == dirb);
        rd_a      = byp_a ? data : mem_q[dira];
        rd_b      = byp_b ? data : mem_q[dirb];
        rd_a_init = byp_a | init_v_q[dira];
        rd_b_init = byp_b | init_v_q[dirb];
    end

    always_comb begin
        opa_d      = opa_q;
        opb_d      = opb_q;
        opa_init_d = opa_init_q;
        opb_init_d = opb_init_q;
        op_valid_d = op_valid_q;
        if (!hold) begin
            op_valid_d = rd_req;
            if (rd_req) begin
                opa_d      = rd_a;
                opb_d      = rd_b;
                opa_init_d = rd_a_init;
                opb_init_d = rd_b_init;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            init_v_q <= '0;
        end else if (write) begin
            mem_q[waddr]    <= data;
            init_v_q[waddr] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opa_q      <= '0;
            opb_q      <= '0;
            op_valid_q <= 1'b0;
            opa_init_q <= 1'b0;
            opb_init_q <= 1'b0;
            wr_ack_q   <= 1'b0;
        end else begin
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            op_valid_q <= op_valid_d;
            opa_init_q <= opa_init_d;
            opb_init_q <= opb_init_d;
            wr_ack_q   <= write;
        end
    end

    assign opa      = opa_q;
    assign opb      = opb_q;
    assign op_valid = op_valid_q;
    assign opa_init = opa_init_q;
    assign opb_init = opb_init_q;
    assign wr_ack   = wr_ack_q;

endmodule
